// File: rtl/if_id_skid_reg_if.sv
// rtl/if_id_skid_reg_if.sv - valid/ready bus carrying one fetched instruction entry
//
// Purpose: bundles the handshake and payload of one IF/ID entry so both sides
//          of the pipeline register use the same signal set.
// Signals:
//   valid       producer presents an entry
//   ready       consumer can take the entry this cycle
//   instr       instruction word (DATA_W bits)
//   pc          program counter of instr (PC_W bits)
//   pred_taken  branch predicted taken for instr
// Modports:
//   master  drives valid/instr/pc/pred_taken, samples ready
//   slave   samples valid/instr/pc/pred_taken, drives ready
interface if_id_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] instr;
  logic [PC_W-1:0]   pc;
  logic              pred_taken;

  modport master (
    output valid,
    output instr,
    output pc,
    output pred_taken,
    input  ready
  );

  modport slave (
    input  valid,
    input  instr,
    input  pc,
    input  pred_taken,
    output ready
  );
endinterface

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - IF/ID pipeline register with one-entry skid buffer and stall counter
//
// Purpose: carries instruction, PC and prediction flag from fetch to decode at one
//          transfer per cycle. A skid slot absorbs the entry accepted in the cycle
//          decode stalls, so in_ready depends only on registered state.
// Ports:
//   clock         system clock, all updates on posedge
//   nreset        synchronous active-low reset, highest priority
//   flush         drop held and incoming entries this edge
//   in_bus        fetch side (slave): valid/instr/pc/pred_taken in, ready out
//   out_bus       decode side (master): valid/instr/pc/pred_taken out, ready in
//   stall_cycles  saturating count of cycles with out valid and not ready
module if_id_skid_reg #(
  parameter int                DATA_W   = 32,
  parameter int                PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}},
  parameter int                CNT_W    = 16
) (
  input  logic                     clock,
  input  logic                     nreset,
  input  logic                     flush,
  if_id_skid_reg_if.slave          in_bus,
  if_id_skid_reg_if.master         out_bus,
  output logic [CNT_W-1:0]         stall_cycles
);

  // main slot: the entry currently presented to decode
  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_instr;
  logic [PC_W-1:0]   r_main_pc;
  logic              r_main_pred;

  // skid slot: entry accepted while main was held by decode
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_instr;
  logic [PC_W-1:0]   r_skid_pc;
  logic              r_skid_pred;

  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_free;
  logic              w_stall;

  // in_ready comes straight from the skid flag, breaking the ready path to decode
  assign w_in_ready  = ~r_skid_valid;
  assign w_in_fire   = in_bus.valid & w_in_ready;
  assign w_out_fire  = r_main_valid & out_bus.ready;
  assign w_main_free = ~r_main_valid | w_out_fire;
  assign w_stall     = r_main_valid & ~out_bus.ready;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_main_valid <= 1'b0;
      r_main_instr <= NOP_WORD;
      r_main_pc    <= '0;
      r_main_pred  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= NOP_WORD;
      r_skid_pc    <= '0;
      r_skid_pred  <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      // the counter observes decode back-pressure and ignores flush
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      if (flush) begin
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_main_free) begin
        // the older skid entry always goes ahead of the incoming one
        if (r_skid_valid) begin
          r_main_valid <= 1'b1;
          r_main_instr <= r_skid_instr;
          r_main_pc    <= r_skid_pc;
          r_main_pred  <= r_skid_pred;
          r_skid_valid <= 1'b0;
        end else if (w_in_fire) begin
          r_main_valid <= 1'b1;
          r_main_instr <= in_bus.instr;
          r_main_pc    <= in_bus.pc;
          r_main_pred  <= in_bus.pred_taken;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_in_fire) begin
        r_skid_valid <= 1'b1;
        r_skid_instr <= in_bus.instr;
        r_skid_pc    <= in_bus.pc;
        r_skid_pred  <= in_bus.pred_taken;
      end
    end
  end

  assign in_bus.ready       = w_in_ready;
  assign out_bus.valid      = r_main_valid;
  assign out_bus.instr      = r_main_valid ? r_main_instr : NOP_WORD;
  assign out_bus.pc         = r_main_valid ? r_main_pc : '0;
  assign out_bus.pred_taken = r_main_valid & r_main_pred;
  assign stall_cycles       = r_stall_cnt;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb/tb_if_id_skid_reg.sv - directed self-checking bench for if_id_skid_reg
module tb_if_id_skid_reg;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 4;

  logic             clock = 1'b0;
  logic             nreset;
  logic             flush;
  logic [CNT_W-1:0] stall_cycles;

  int n_pass  = 0;
  int n_total = 0;

  if_id_skid_reg_if #(.DATA_W(DATA_W), .PC_W(PC_W)) in_bus ();
  if_id_skid_reg_if #(.DATA_W(DATA_W), .PC_W(PC_W)) out_bus ();

  if_id_skid_reg #(
    .DATA_W   (DATA_W),
    .PC_W     (PC_W),
    .NOP_WORD ({DATA_W{1'b0}}),
    .CNT_W    (CNT_W)
  ) dut (
    .clock        (clock),
    .nreset       (nreset),
    .flush        (flush),
    .in_bus       (in_bus),
    .out_bus      (out_bus),
    .stall_cycles (stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_in(input logic v, input logic [31:0] instr, input logic [31:0] pc, input logic pred);
    in_bus.valid      = v;
    in_bus.instr      = instr;
    in_bus.pc         = pc;
    in_bus.pred_taken = pred;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] instr,
                         input logic [31:0] pc, input logic pred);
    chk({tag, ".valid"}, 64'(out_bus.valid), 64'(v));
    chk({tag, ".instr"}, 64'(out_bus.instr), 64'(instr));
    chk({tag, ".pc"},    64'(out_bus.pc),    64'(pc));
    chk({tag, ".pred"},  64'(out_bus.pred_taken), 64'(pred));
  endtask

  initial begin
    nreset = 1'b0;
    flush  = 1'b0;
    out_bus.ready = 1'b0;
    drive_in(1'b1, 32'hDEAD, 32'h44, 1'b1);

    // reset, with inputs active to show they are ignored
    step();
    chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b0);
    chk("reset.in_ready", 64'(in_bus.ready), 64'd1);
    chk("reset.stall", 64'(stall_cycles), 64'd0);
    nreset = 1'b1;
    drive_in(1'b0, 32'h0, 32'h0, 1'b0);

    // streaming: one transfer per cycle, 1-cycle latency
    out_bus.ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_in(1'b1, 32'h100 + i, 32'h1000 + 4 * i, i[0]);
      chk("stream.in_ready", 64'(in_bus.ready), 64'd1);
      step();
      chk_out("stream.out", 1'b1, 32'h100 + i, 32'h1000 + 4 * i, i[0]);
    end
    drive_in(1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk("stream.drained", 64'(out_bus.valid), 64'd0);
    chk("stream.stall", 64'(stall_cycles), 64'd0);

    // back-pressure: A1 held in main, A2 in skid, A3 refused
    out_bus.ready = 1'b0;
    drive_in(1'b1, 32'hA1, 32'h200, 1'b0);
    step();
    chk_out("bp.a1", 1'b1, 32'hA1, 32'h200, 1'b0);
    chk("bp.stall0", 64'(stall_cycles), 64'd0);
    drive_in(1'b1, 32'hA2, 32'h204, 1'b1);
    step();
    chk_out("bp.hold", 1'b1, 32'hA1, 32'h200, 1'b0);
    chk("bp.in_ready", 64'(in_bus.ready), 64'd0);
    chk("bp.stall1", 64'(stall_cycles), 64'd1);
    drive_in(1'b1, 32'hA3, 32'h208, 1'b0);
    step();
    chk_out("bp.hold2", 1'b1, 32'hA1, 32'h200, 1'b0);
    chk("bp.in_ready2", 64'(in_bus.ready), 64'd0);
    chk("bp.stall2", 64'(stall_cycles), 64'd2);
    drive_in(1'b0, 32'h0, 32'h0, 1'b0);
    out_bus.ready = 1'b1;
    step();
    chk_out("bp.a2", 1'b1, 32'hA2, 32'h204, 1'b1);
    chk("bp.in_ready3", 64'(in_bus.ready), 64'd1);
    chk("bp.stall3", 64'(stall_cycles), 64'd2);
    step();
    chk_out("bp.empty", 1'b0, 32'h0, 32'h0, 1'b0);

    // flush with both slots full
    out_bus.ready = 1'b0;
    drive_in(1'b1, 32'hB1, 32'h300, 1'b1);
    step();
    drive_in(1'b1, 32'hB2, 32'h304, 1'b1);
    step();
    chk("fl.in_ready_full", 64'(in_bus.ready), 64'd0);
    chk("fl.stall_pre", 64'(stall_cycles), 64'd3);
    drive_in(1'b0, 32'h0, 32'h0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_out("fl.after", 1'b0, 32'h0, 32'h0, 1'b0);
    chk("fl.in_ready", 64'(in_bus.ready), 64'd1);
    chk("fl.stall", 64'(stall_cycles), 64'd4);
    out_bus.ready = 1'b1;
    step();
    chk("fl.no_b1", 64'(out_bus.valid), 64'd0);
    step();
    chk("fl.no_b2", 64'(out_bus.valid), 64'd0);

    // flush coincident with an accepted input
    drive_in(1'b1, 32'hBEEF, 32'h400, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive_in(1'b0, 32'h0, 32'h0, 1'b0);
    chk("fl2.dropped", 64'(out_bus.valid), 64'd0);
    step();
    chk("fl2.still_empty", 64'(out_bus.valid), 64'd0);
    drive_in(1'b1, 32'hC1, 32'h500, 1'b0);
    step();
    drive_in(1'b0, 32'h0, 32'h0, 1'b0);
    chk_out("fl2.next", 1'b1, 32'hC1, 32'h500, 1'b0);
    step();
    chk("fl2.drained", 64'(out_bus.valid), 64'd0);

    // stall counter saturation
    nreset = 1'b0;
    step();
    nreset = 1'b1;
    chk("sat.reset", 64'(stall_cycles), 64'd0);
    out_bus.ready = 1'b0;
    drive_in(1'b1, 32'hD1, 32'h600, 1'b0);
    step();
    drive_in(1'b0, 32'h0, 32'h0, 1'b0);
    chk("sat.start", 64'(stall_cycles), 64'd0);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("sat.k%0d", k), 64'(stall_cycles), 64'((k < 15) ? k : 15));
    end
    chk_out("sat.hold", 1'b1, 32'hD1, 32'h600, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sat.after_flush", 64'(stall_cycles), 64'd15);
    chk("sat.flushed", 64'(out_bus.valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
